// File: rtl/modexpa7_fifo_word_adder.sv
// Multi-word adder: pops N words from the word FIFO, adds the matching words of a
// bank operand with carry propagation, and writes the N sum words to a result bank.
module modexpa7_fifo_word_adder #(
    parameter int unsigned WORD_WIDTH         = 32,
    parameter int unsigned OPERAND_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    output logic                          rdy,
    input  logic [OPERAND_ADDR_WIDTH-1:0] n_num_words,
    output logic                          fifo_rd_en,
    input  logic [WORD_WIDTH-1:0]         fifo_d_out,
    output logic [OPERAND_ADDR_WIDTH-1:0] b_bram_addr,
    input  logic [WORD_WIDTH-1:0]         b_bram_out,
    output logic [OPERAND_ADDR_WIDTH-1:0] r_bram_addr,
    output logic                          r_bram_wr,
    output logic [WORD_WIDTH-1:0]         r_bram_in,
    output logic                          carry_out
);

    localparam int unsigned SUM_W = WORD_WIDTH + 1;
    localparam int unsigned AW    = OPERAND_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   n_q;
    logic [AW-1:0]   rd_addr_q;
    logic            rd_vld_q;
    logic            carry_q;
    logic [SUM_W-1:0] sum_d;

    // Word add for the operand pair returned by last cycle's issue.
    assign sum_d = SUM_W'(fifo_d_out) + SUM_W'(b_bram_out) + SUM_W'(carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            rd_addr_q   <= '0;
            rd_vld_q    <= 1'b0;
            carry_q     <= 1'b0;
            rdy         <= 1'b1;
            fifo_rd_en  <= 1'b0;
            b_bram_addr <= '0;
            r_bram_addr <= '0;
            r_bram_wr   <= 1'b0;
            r_bram_in   <= '0;
            carry_out   <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            r_bram_wr  <= 1'b0;
            rd_vld_q   <= fifo_rd_en;
            rd_addr_q  <= b_bram_addr;

            if (rd_vld_q) begin
                {carry_q, r_bram_in} <= sum_d;
                r_bram_wr            <= 1'b1;
                r_bram_addr          <= rd_addr_q;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    rdy     <= 1'b1;
                    if (ena) begin
                        state_q     <= ST_ISSUE;
                        n_q         <= n_num_words;
                        rdy         <= 1'b0;
                        fifo_rd_en  <= 1'b1;
                        b_bram_addr <= '0;
                        carry_q     <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // Exit on the latched last index so a full-length run never wraps.
                    if (b_bram_addr == n_q) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        fifo_rd_en  <= 1'b1;
                        b_bram_addr <= b_bram_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_bram_wr && (r_bram_addr == n_q)) begin
                        state_q   <= ST_DONE;
                        rdy       <= 1'b1;
                        carry_out <= carry_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/modexpa7_fifo_word_adder.md
Name: modexpa7_fifo_word_adder

Overview:
- Multi-word adder stage directly downstream of the modexpa7 word FIFO.
- Pops N operand words from the FIFO, LSW first, and reads the matching words of a second operand from a bank memory.
- Adds the two streams word-by-word with carry propagation and writes the sum words into a result bank.
- Used to fold FIFO-buffered partial products into an accumulator operand during Montgomery multiplication.

Parameters:
- WORD_WIDTH, 32, width of one operand word; must equal the FIFO BUS_WIDTH.
- OPERAND_ADDR_WIDTH, 5, bank address width; max operand length is 2**OPERAND_ADDR_WIDTH words.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ena  input  1  start request, sampled only when rdy=1
- rdy  output  1  high when idle or done; low while an operation is in progress
- n_num_words  input  OPERAND_ADDR_WIDTH  number of words minus one (N = n_num_words+1); sampled with ena
- fifo_rd_en  output  1  FIFO pop strobe
- fifo_d_out  input  WORD_WIDTH  FIFO registered output, valid one cycle after fifo_rd_en
- b_bram_addr  output  OPERAND_ADDR_WIDTH  second-operand read address
- b_bram_out  input  WORD_WIDTH  second-operand data, valid one cycle after the address
- r_bram_addr  output  OPERAND_ADDR_WIDTH  result write address
- r_bram_wr  output  1  result write enable
- r_bram_in  output  WORD_WIDTH  result write data
- carry_out  output  1  final carry of the last completed operation

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: rdy=1, fifo_rd_en=0, r_bram_wr=0, carry_out=0, all addresses 0, r_bram_in=0; FSM to IDLE; internal carry cleared.
- All outputs are registered.
- FSM states:
  - IDLE: waits for ena.
  - ISSUE: issues N reads.
  - DRAIN: completes the final adds and writes.
  - DONE: single cycle, returns to IDLE.
- Start: in IDLE with ena=1 at edge T0:
  - latch N;
  - rdy falls, visible from cycle T0+1;
  - clear the internal carry.
- Read issue: fifo_rd_en=1 for exactly N consecutive cycles, starting in the cycle after ena is sampled.
  - In the k-th such cycle (k=0..N-1), b_bram_addr=k.
- Add: one cycle after issue k, fifo_d_out and b_bram_out hold word k.
  - Compute {c, s} = fifo_d_out + b_bram_out + carry at WORD_WIDTH+1 bits.
  - Register s into r_bram_in and c into carry.
- Write: r_bram_wr=1 with r_bram_addr=k two cycles after issue k.
  - Writes therefore occur in N consecutive cycles.
  - Write count is exactly N, with no gaps.
- Completion:
  - In the cycle after the last write, r_bram_wr=0, rdy=1, and carry_out = final carry.
  - carry_out holds until the next operation's completion or rst.
- Total latency: rdy is low for N+2 cycles.
- Boundary conditions:
  - n_num_words=0 (N=1): one pop, one write to address 0.
  - n_num_words = all ones: 2**OPERAND_ADDR_WIDTH words. The address counter must not wrap before the last issue, and the ISSUE exit is compared against the latched N, not against counter overflow.
  - ena while rdy=0: ignored, and does not extend or restart the operation.
  - ena held high continuously: a new operation starts on the cycle rdy is observed high. The back-to-back gap is exactly one rdy=1 cycle.
  - Changes to n_num_words while busy: no effect.
  - rst mid-operation: immediate return to IDLE on the next edge with reset values.
    - Pending writes are dropped.
    - FIFO pointer resynchronisation is the controller's responsibility; the FIFO shares the same rst.
- The block never pops more than N words and never asserts fifo_rd_en outside ISSUE.
- The word sum wraps modulo 2**WORD_WIDTH; the overflow goes only into the carry.

Test Plan:
- N=1: FIFO word 0x00000005, B[0]=0x00000003 -> exactly one fifo_rd_en pulse; r_bram_wr at addr 0 with 0x00000008; carry_out=0; rdy low for 3 cycles.
- Carry chain, N=4: FIFO words {0xFFFFFFFF x4}, B={0x00000001,0,0,0} -> R={0,0,0,0}; carry_out=1; writes on 4 consecutive cycles to addresses 0..3 in order.
- Max length, N=32 (n_num_words=31): random operands -> R matches a 1024-bit reference sum; exactly 32 pops and 32 writes; no address wrap.
- ena held high through two operations (N=2, then N=2 with new data) -> second fifo_rd_en burst starts the cycle rdy is high; one-cycle rdy gap; both results correct; second carry_out replaces the first.
- rst asserted on the third issue cycle of an N=8 operation -> next cycle: rdy=1, fifo_rd_en=0, r_bram_wr=0, carry_out=0. A subsequent N=1 operation completes correctly.
- Pulse ena while busy (N=4) -> exactly 4 pops and 4 writes; no restart; n_num_words changed mid-operation has no effect.
